arm_regfile_32x64: RTL and testbench
====================================

Name: arm_regfile_32x64

Overview:
- ARM-style 64-bit integer register file: 32 architectural registers, two combinational read ports and one synchronous write port.
- Register 31 (XZR) always reads zero; writes to it are discarded.
- Sits in the decode/register-read stage of the datapath and feeds the ALU operands.
- Internally: a 5-to-32 write-enable decoder, a 32-entry 64-bit register bank and two 32:1 64-bit read muxes.

Parameters:
- DELAY, 50, simulation-only propagation delay in time units, applied to decoder and read-mux outputs; ignored by synthesis; 0 allowed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; clears every register to 0.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  write address.
- WriteData  input  64  write data.
- ReadRegister1  input  5  read port 1 address.
- ReadRegister2  input  5  read port 2 address.
- ReadData1  output  64  read port 1 data, combinational.
- ReadData2  output  64  read port 2 data, combinational.

Behaviour:
- Storage: registers X0..X30, 64 bits each. X31 has no storage and is hard-wired to 0.
- Reset: at posedge clk with rst=0, X0..X30 become 0. A write presented in the same cycle is ignored. Reset has priority over write.
- Write: at posedge clk with rst=1 and RegWrite=1, register[WriteRegister] <= WriteData. No other register changes.
  - WriteRegister=31: no state change.
  - RegWrite=0: no state change, whatever WriteRegister and WriteData are.
- Decoder: produces a one-hot 32-bit enable from WriteRegister, gated by RegWrite. All bits are 0 when RegWrite=0. Bit 31 is never acted on.
- Read: ReadDataN = register[ReadRegisterN], combinational, zero clock latency, settling within DELAY after any address or state change.
  - ReadRegisterN=31 returns 64'h0 in every case.
- Both read ports are independent and may address the same register, or the write register, simultaneously.
- Read during write, same address, feature disabled: the read returns the old value until the clock edge and the new value after it (write-then-visible-next-cycle).
- After power-up, before the first reset, register contents are undefined (X in simulation). X31 still reads 0.
- No X propagation from X31 under any circumstance.

Optional Feature:
- Macro: ARM_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If RegWrite=1, rst=1, WriteRegister==ReadRegisterN and WriteRegister!=31, then ReadDataN = WriteData combinationally in the same cycle.
  - X31 is still forced to 0.
  - Forwarding is suppressed while rst=0.
- Undefined: no forwarding; reads always return stored contents.

Decomposition:
- Shared package arm_regfile_pkg:
  - NUM_REGS=32, ADDR_W=5, DATA_W=64, ZERO_REG=5'd31.
  - typedef reg_addr_t (logic [4:0]).
  - typedef reg_data_t (logic [63:0]).
- One sub-module, regfile_read_mux: 32:1 mux of 64-bit words with a DELAY parameter and a forced-zero entry for ZERO_REG. Instantiated once per read port.
- The decoder and register bank are coded inline in the top module.

Test Plan:
- Reset clears: write X5=64'hDEAD_BEEF, then assert rst=0 for 1 cycle with RegWrite=1, WriteRegister=7, WriteData=64'h1234 -> X5 and X7 read 0.
- Basic write/read: write X3=64'h0123_4567_89AB_CDEF, then X10=64'h3FF; read R1=3, R2=10 -> 64'h0123_4567_89AB_CDEF and 64'h3FF; the other 29 registers read 0.
- Zero register: write X31=64'hFFFF_FFFF_FFFF_FFFF with RegWrite=1 -> ReadData1 and ReadData2 at address 31 both return 0; no other register changed.
- RegWrite gating: RegWrite=0, WriteRegister=4, WriteData=64'hAAAA -> X4 keeps its prior value (0 after reset).
- Read-during-write, same address: X8=64'h11, then RegWrite=1, WriteRegister=8, WriteData=64'h22, R1=8.
  - Without macro: 64'h11 before the edge, 64'h22 after it.
  - With ARM_REGFILE_BYPASS_EN: 64'h22 immediately.
- Random regression: 1000 cycles of random addresses, data and RegWrite, compared every cycle against a 32-entry reference model that enforces X31=0 -> zero mismatches.

Source files
------------

// File: rtl/arm_regfile_pkg.sv
// Shared definitions for the 32 x 64-bit ARM-style integer register file.
//   NUM_REGS   number of architectural registers (X0..X31)
//   ADDR_W     register address width
//   DATA_W     register data width
//   ZERO_REG   address of XZR, which has no storage and always reads zero
package arm_regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/arm_regfile_read_mux.sv
// regfile_read_mux: 32:1 selector of 64-bit words for one register-file read
// port. Entries 0..30 come from the register bank; entry ZERO_REG is forced
// to zero and has no input, so nothing undefined can leak out of it.
//
// Ports:
//   regs   in   stored words X0..X30, packed, X0 in the lowest slot
//   sel    in   read address
//   rdata  out  selected word, combinational
//
// DELAY is a simulation-timing annotation for the read path. The model here
// settles in zero time; only a non-negative value is meaningful.
module regfile_read_mux
    import arm_regfile_pkg::*;
#(
    parameter int DELAY = 50
) (
    input  logic [NUM_REGS-2:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               sel,
    output logic [DATA_W-1:0]               rdata
);

    if (DELAY >= 0) begin : g_mux
        always_comb begin
            rdata = '0;
            if (sel != ZERO_REG) begin
                rdata = regs[sel];
            end
        end
    end else begin : g_bad_delay
        assign rdata = '0;
    end

endmodule

// File: rtl/arm_regfile_32x64.sv
// arm_regfile_32x64: ARM-style 64-bit integer register file, 32 architectural
// registers (X31 = XZR reads zero, writes discarded), two combinational read
// ports and one synchronous write port. Feeds the ALU operands from the
// decode/register-read stage.
//
// Ports:
//   clk            in   clock, all updates on the rising edge
//   rst            in   synchronous active-low reset, clears X0..X30
//   RegWrite       in   write enable
//   WriteRegister  in   write address
//   WriteData      in   write data
//   ReadRegister1  in   read port 1 address
//   ReadRegister2  in   read port 2 address
//   ReadData1      out  read port 1 data, combinational
//   ReadData2      out  read port 2 data, combinational
//
// Build option: define ARM_REGFILE_BYPASS_EN to forward WriteData to a read
// port addressing the register being written in the same cycle (not X31,
// not while in reset). Without it, a write becomes visible after the edge.
module arm_regfile_32x64
    import arm_regfile_pkg::*;
#(
    parameter int DELAY = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [NUM_REGS-1:0]             we_dec;
    logic [NUM_REGS-2:0][DATA_W-1:0] bank;
    logic [DATA_W-1:0]               mux1;
    logic [DATA_W-1:0]               mux2;
    logic                            unused_we_zero;

    // One-hot write enable. The XZR bit is produced but has no register behind it.
    always_comb begin
        we_dec = '0;
        if (RegWrite) begin
            we_dec[WriteRegister] = 1'b1;
        end
    end

    assign unused_we_zero = we_dec[ZERO_REG];

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (we_dec[i]) begin
                    bank[i] <= WriteData;
                end
            end
        end
    end

    regfile_read_mux #(.DELAY(DELAY)) u_read_mux1 (
        .regs  (bank),
        .sel   (ReadRegister1),
        .rdata (mux1)
    );

    regfile_read_mux #(.DELAY(DELAY)) u_read_mux2 (
        .regs  (bank),
        .sel   (ReadRegister2),
        .rdata (mux2)
    );

`ifdef ARM_REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Excluding ZERO_REG from the match keeps X31 at zero on the forward path too.
    assign fwd1 = rst && RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != ZERO_REG);
    assign fwd2 = rst && RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != ZERO_REG);

    assign ReadData1 = fwd1 ? WriteData : mux1;
    assign ReadData2 = fwd2 ? WriteData : mux2;
`else
    assign ReadData1 = mux1;
    assign ReadData2 = mux2;
`endif

endmodule

// File: tb/tb_arm_regfile_32x64.sv
module tb_arm_regfile_32x64;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];

    // Reference: architectural register contents, X31 entry never consulted.
    logic [63:0] model [32];

    arm_regfile_32x64 #(.DELAY(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [4:0] a);
        logic [63:0] v;
        if (a == 5'd31) return 64'h0;
        v = model[a];
`ifdef ARM_REGFILE_BYPASS_EN
        if (rst && RegWrite && WriteRegister == a) v = WriteData;
`endif
        return v;
    endfunction

    task automatic push(input string name, input int port, input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs and queue the model's view of both read ports.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input string name);
        rst           = r;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        push(name, 1, model_read(a1));
        push(name, 2, model_read(a2));
    endtask

    // Advance past the clock edge, applying the architectural update rules.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] = WriteData;
        end
        #1;
    endtask

    // Monitor: read ports are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e   = sb.pop_front();
            act = (e.port == 1) ? ReadData1 : ReadData2;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        @(posedge clk); #1;

        // Power-up: storage undefined, XZR still zero.
        drive(1, 0, 5'd0, 64'h0, 5'd31, 5'd31, "powerup_xzr");
        push("powerup_xzr_const", 1, 64'h0);
        tick();

        // Reset clears, and a write in the reset cycle is ignored.
        drive(0, 0, 5'd0, 64'h0, 5'd31, 5'd31, "init_reset");
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        tick();
        drive(1, 1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd7, "write_x5");
        tick();
        drive(1, 0, 5'd0, 64'h0, 5'd5, 5'd7, "x5_written");
        push("x5_written_const", 1, 64'hDEAD_BEEF);
        tick();
        drive(0, 1, 5'd7, 64'h1234, 5'd5, 5'd7, "reset_with_write");
        tick();
        drive(1, 0, 5'd7, 64'h1234, 5'd5, 5'd7, "after_reset");
        push("after_reset_x5", 1, 64'h0);
        push("after_reset_x7", 2, 64'h0);
        tick();

        // Basic write/read and all other registers zero.
        drive(1, 1, 5'd3, 64'h0123_4567_89AB_CDEF, 5'd31, 5'd31, "write_x3");
        tick();
        drive(1, 1, 5'd10, 64'h3FF, 5'd31, 5'd31, "write_x10");
        tick();
        drive(1, 0, 5'd0, 64'h0, 5'd3, 5'd10, "read_x3_x10");
        push("read_x3_const", 1, 64'h0123_4567_89AB_CDEF);
        push("read_x10_const", 2, 64'h3FF);
        tick();
        for (int i = 0; i < 32; i += 2) begin
            drive(1, 0, 5'd0, 64'h0, 5'(i), 5'(i + 1), "sweep");
            tick();
        end

        // Zero register write is discarded.
        drive(1, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, "write_xzr");
        tick();
        drive(1, 0, 5'd0, 64'h0, 5'd31, 5'd31, "read_xzr");
        push("read_xzr_const", 2, 64'h0);
        tick();
        for (int i = 0; i < 32; i += 2) begin
            drive(1, 0, 5'd0, 64'h0, 5'(i), 5'(i + 1), "sweep_after_xzr");
            tick();
        end

        // RegWrite gating.
        drive(1, 0, 5'd4, 64'hAAAA, 5'd4, 5'd4, "gated_cycle");
        tick();
        drive(1, 0, 5'd0, 64'h0, 5'd4, 5'd31, "gated_read");
        push("gated_read_const", 1, 64'h0);
        tick();

        // Read during write, same address.
        drive(1, 1, 5'd8, 64'h11, 5'd31, 5'd31, "write_x8");
        tick();
        drive(1, 1, 5'd8, 64'h22, 5'd8, 5'd8, "rdw_same_cycle");
`ifdef ARM_REGFILE_BYPASS_EN
        push("rdw_same_cycle_const", 1, 64'h22);
`else
        push("rdw_same_cycle_const", 1, 64'h11);
`endif
        tick();
        drive(1, 0, 5'd0, 64'h0, 5'd8, 5'd31, "rdw_next_cycle");
        push("rdw_next_cycle_const", 1, 64'h22);
        tick();

        // Random regression against the model.
        for (int n = 0; n < 1000; n++) begin
            logic r, we;
            logic [4:0] wa, a1, a2;
            logic [63:0] wd;
            r  = ($urandom_range(0, 49) != 0);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            wd = {$urandom(), $urandom()};
            drive(r, we, wa, wd, a1, a2, "random");
            tick();
        end

        RegWrite = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
